// File: rtl/uart_mmio_peripheral_if.sv
// Decoder-side bus for the UART slot: chip select, write strobe, word offset,
// write data and combinational read data.
interface uart_mmio_peripheral_if;
  logic        Select;
  logic        Write;
  logic [2:0]  Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport master (output Select, output Write, output Addr, output DataIn, input DataOut);
  modport slave  (input Select, input Write, input Addr, input DataIn, output DataOut);
endinterface

// File: rtl/uart_mmio_peripheral.sv
// Memory-mapped UART: baud-divided TX/RX FSMs behind a 5-word register window.
// Define UART_PARITY_EN to add an even-parity bit to both directions.
module uart_mmio_peripheral #(
  parameter int DEFAULT_DIV = 434,
  parameter int DIV_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_mmio_peripheral_if.slave bus,
  input  logic                  uart_rx,
  output logic                  uart_tx
);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic wr_en, wr_tx, wr_baud, wr_ctrl, clr_valid, clr_err;
  logic unused_data;

  assign wr_en     = bus.Select & bus.Write;
  assign wr_tx     = wr_en && (bus.Addr == 3'd0);
  assign wr_baud   = wr_en && (bus.Addr == 3'd3);
  assign wr_ctrl   = wr_en && (bus.Addr == 3'd4);
  assign clr_valid = wr_ctrl & bus.DataIn[0];
  assign clr_err   = wr_ctrl & bus.DataIn[1];
  assign unused_data = ^bus.DataIn[31:DIV_W];

  logic [DIV_W-1:0] baud_q, baud_d, eff_div;

  assign eff_div = (baud_q < DIV_MIN) ? DIV_MIN : baud_q;
  assign baud_d  = wr_baud ? bus.DataIn[DIV_W-1:0] : baud_q;

  // ---------------- transmitter ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       txdata_q, txdata_d;
  logic             tx_out_q, tx_out_d;
  logic             tx_busy, tx_tick, tx_accept;

  assign tx_busy   = (tx_state_q != TX_IDLE);
  assign tx_tick   = (tx_cnt_q == tx_div_q - DIV_ONE);
  // The edge that ends STOP may also start the next frame.
  assign tx_accept = wr_tx && (!tx_busy || (tx_state_q == TX_STOP && tx_tick));
  assign uart_tx   = tx_out_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    txdata_d   = txdata_q;
    tx_out_d   = 1'b1;
    if (tx_busy) begin
      tx_cnt_d = tx_tick ? '0 : tx_cnt_q + DIV_ONE;
    end
    case (tx_state_q)
      TX_START: begin
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_tick) tx_state_d = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (tx_tick) tx_state_d = TX_IDLE;
      end
      default: ;
    endcase
    if (tx_accept) begin
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_div_d   = eff_div;
      tx_bit_d   = 3'd0;
      txdata_d   = bus.DataIn[7:0];
    end
    // Line level is registered from the next state so uart_tx is glitch-free.
    case (tx_state_d)
      TX_START: tx_out_d = 1'b0;
      TX_DATA:  tx_out_d = txdata_d[tx_bit_d];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_out_d = ^txdata_d;
`endif
      default:  tx_out_d = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_fall, rx_tick, rx_mid, rx_done, rx_stop_bad;
`ifdef UART_PARITY_EN
  logic             rx_perr_q, rx_perr_d;
`endif

  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign rx_tick = (rx_cnt_q == rx_div_q - DIV_ONE);
  assign rx_mid  = (rx_cnt_q == (rx_div_q >> 1) - DIV_ONE);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_done     = 1'b0;
    rx_stop_bad = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d   = rx_perr_q;
`endif
    if (rx_state_q != RX_IDLE) begin
      rx_cnt_d = rx_cnt_q + DIV_ONE;
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_div_d   = eff_div;
        end
      end
      RX_START: begin
        // A line that is high again at mid-start was a glitch.
        if (rx_mid) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_perr_d  = rx_s2_q ^ (^rx_shift_q);
          rx_state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_tick) begin
          rx_cnt_d    = '0;
          rx_done     = 1'b1;
          rx_stop_bad = ~rx_s2_q;
          rx_state_d  = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- status flags ----------------
  logic [7:0] rxdata_q, rxdata_d;
  logic       rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic       frame_err_q, frame_err_d;
  logic       parity_flag;
`ifdef UART_PARITY_EN
  logic       parity_err_q, parity_err_d;
  assign parity_flag = parity_err_q;
`else
  assign parity_flag = 1'b0;
`endif

  // Clears apply first so a completion on the same edge wins.
  always_comb begin
    rxdata_d     = rxdata_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    frame_err_d  = frame_err_q;
`ifdef UART_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (clr_valid) rx_valid_d = 1'b0;
    if (clr_err) begin
      rx_overrun_d = 1'b0;
      frame_err_d  = 1'b0;
`ifdef UART_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
    if (rx_done) begin
      rxdata_d   = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !clr_valid) rx_overrun_d = 1'b1;
      if (rx_stop_bad) frame_err_d = 1'b1;
`ifdef UART_PARITY_EN
      if (rx_perr_q) parity_err_d = 1'b1;
`endif
    end
  end

  always_comb begin
    bus.DataOut = '0;
    case (bus.Addr)
      3'd0: bus.DataOut[7:0]       = txdata_q;
      3'd1: bus.DataOut[7:0]       = rxdata_q;
      3'd2: bus.DataOut[4:0]       = {parity_flag, frame_err_q, rx_overrun_q, rx_valid_q, tx_busy};
      3'd3: bus.DataOut[DIV_W-1:0] = baud_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q       <= DIV_W'(DEFAULT_DIV);
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_div_q     <= DIV_MIN;
      tx_bit_q     <= 3'd0;
      txdata_q     <= 8'd0;
      tx_out_q     <= 1'b1;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_div_q     <= DIV_MIN;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'd0;
      rxdata_q     <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      baud_q       <= baud_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_div_q     <= tx_div_d;
      tx_bit_q     <= tx_bit_d;
      txdata_q     <= txdata_d;
      tx_out_q     <= tx_out_d;
      rx_s1_q      <= uart_rx;
      rx_s2_q      <= rx_s1_q;
      rx_s3_q      <= rx_s2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_div_q     <= rx_div_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rxdata_q     <= rxdata_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_PARITY_EN
      rx_perr_q    <= rx_perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

endmodule
